pdm_audio_dac: RTL and testbench

//  Parametrised multi-channel PDM audio DAC; successor of the fixed 15-bit

---
 rtl/pdm_audio_dac_if.sv | 17 +
 rtl/pdm_audio_dac.sv | 215 +++++++++++++++++++++
 tb/tb_pdm_audio_dac.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_audio_dac_if.sv
// rtl/pdm_audio_dac_if.sv - frame handshake bundle feeding pdm_audio_dac
// Purpose: carries one multi-channel audio frame per valid/ready transfer.
// Signals:
//   sample       CHANNELS*WIDTH  frame, channel n at [n*WIDTH +: WIDTH]
//   sample_valid 1               source holds a frame
//   sample_ready 1               sink FIFO can take a frame
interface pdm_audio_dac_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 12
);
  logic [CHANNELS*WIDTH-1:0] sample;
  logic                      sample_valid;
  logic                      sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/pdm_audio_dac.sv
// rtl/pdm_audio_dac.sv - multi-channel PDM audio DAC with frame FIFO and gain-ramp mute
// Purpose: 2-deep frame FIFO, per-channel 1st/2nd order PDM modulators, click-free mute.
// Ports:
//   clk_i, rstn_i  clock, synchronous active-low reset
//   s_if           frame handshake (slave side)
//   order2_i       0 = first order, 1 = second order
//   mute_i         request mute (gain ramps down)
//   pdm_o          registered PDM bitstreams, one per channel
//   pdm_en_o       amplifier enable
//   muted_o        gain ramp is in MUTED
//   underrun_o     1-cycle pulse: frame tick found the FIFO empty
module pdm_audio_dac #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 12,
  parameter int TICK_DIV    = 1,
  parameter int FRAME_TICKS = 256,
  parameter int GAIN_BITS   = 6
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  pdm_audio_dac_if.slave      s_if,
  input  logic                order2_i,
  input  logic                mute_i,
  output logic [CHANNELS-1:0] pdm_o,
  output logic                pdm_en_o,
  output logic                muted_o,
  output logic                underrun_o
);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(FRAME_TICKS);
  localparam int GW = GAIN_BITS + 1;
  localparam int IW = WIDTH + 4;
  localparam int EW = IW + 2;  // headroom so integrator sums never wrap before saturation
  localparam logic [GW-1:0] GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GW-1:0] GAIN_TOP  = GAIN_FULL - 1'b1;
  localparam logic [GW-1:0] GAIN_ONE  = GW'(1);
  localparam logic signed [EW-1:0] FB_FULL = EW'(2 ** WIDTH);
  localparam logic signed [EW-1:0] SAT_HI  = EW'((2 ** (IW - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_LO  = EW'(-(2 ** (IW - 1)));

  typedef enum logic [1:0] {ST_MUTED, ST_RAMP_UP, ST_RUN, ST_RAMP_DOWN} state_t;

  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > SAT_HI)      sat = SAT_HI[IW-1:0];
    else if (v < SAT_LO) sat = SAT_LO[IW-1:0];
    else                 sat = v[IW-1:0];
  endfunction

  logic [DW-1:0] r_div;
  logic [FW-1:0] r_frm;
  logic          w_tick, w_frame_tick;

  logic [CHANNELS*WIDTH-1:0] r_mem [2];
  logic                      r_wptr, r_rptr, r_ready, r_underrun;
  logic [1:0]                r_count, w_count_nxt;
  logic                      w_push, w_pop;
  logic [WIDTH-1:0]          r_cur [CHANNELS];

  state_t        r_state;
  logic [GW-1:0] r_gain;
  logic          r_en, r_muted, w_muted_nxt;

  logic                 r_order_q, r_clr_pend, w_order_chg;
  logic [WIDTH-1:0]     r_acc [CHANNELS];
  logic signed [IW-1:0] r_i1 [CHANNELS];
  logic signed [IW-1:0] r_i2 [CHANNELS];
  logic [CHANNELS-1:0]  r_pdm;

  logic [WIDTH+GW-1:0]  w_prod [CHANNELS];
  logic [WIDTH-1:0]     w_x [CHANNELS];
  logic [WIDTH:0]       w_sum1 [CHANNELS];
  logic signed [IW-1:0] w_i1_nxt [CHANNELS];
  logic signed [IW-1:0] w_i2_nxt [CHANNELS];
  logic [CHANNELS-1:0]  w_carry, w_y, w_unused;

  assign w_tick       = (r_div == DW'(TICK_DIV - 1));
  assign w_frame_tick = w_tick && (r_frm == FW'(FRAME_TICKS - 1));

  assign w_push      = s_if.sample_valid && r_ready;
  assign w_pop       = w_frame_tick && (r_count != 2'd0);
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // Mirrors the FSM below so the enable and the forced-zero PDM output change on the same edge.
  assign w_muted_nxt = (r_state == ST_MUTED) ? !(w_frame_tick && !mute_i)
                                             : (w_frame_tick && mute_i && (r_gain <= GAIN_ONE));
  assign w_order_chg = (order2_i != r_order_q);

  assign s_if.sample_ready = r_ready;
  assign pdm_o      = r_pdm;
  assign pdm_en_o   = r_en;
  assign muted_o    = r_muted;
  assign underrun_o = r_underrun;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_div <= '0;
      r_frm <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      r_frm <= w_frame_tick ? '0 : r_frm + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // FIFO: a push into a full FIFO is impossible because ready was already low.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) r_cur[n] <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_ready    <= (w_count_nxt != 2'd2);
      r_underrun <= w_frame_tick && (r_count == 2'd0);
      if (w_push) begin
        r_mem[r_wptr] <= s_if.sample;
        r_wptr        <= !r_wptr;
      end
      if (w_pop) begin
        for (int n = 0; n < CHANNELS; n++) r_cur[n] <= r_mem[r_rptr][n*WIDTH +: WIDTH];
        r_rptr <= !r_rptr;
      end
    end
  end

  // Gain ramp: direction follows mute_i at each frame tick, so a reversal resumes from the current gain.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= ST_MUTED;
      r_gain  <= '0;
      r_en    <= 1'b0;
      r_muted <= 1'b0;
    end else begin
      r_en    <= !w_muted_nxt;
      r_muted <= w_muted_nxt;
      if (w_frame_tick) begin
        case (r_state)
          ST_MUTED: if (!mute_i) r_state <= ST_RAMP_UP;
          default: begin
            if (mute_i) begin
              if (r_gain <= GAIN_ONE) begin
                r_gain  <= '0;
                r_state <= ST_MUTED;
              end else begin
                r_gain  <= r_gain - 1'b1;
                r_state <= ST_RAMP_DOWN;
              end
            end else if (r_gain == GAIN_TOP) begin
              r_gain  <= GAIN_FULL;
              r_state <= ST_RUN;
            end else if (r_gain != GAIN_FULL) begin
              r_gain  <= r_gain + 1'b1;
              r_state <= ST_RAMP_UP;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      w_prod[n]   = {{GW{1'b0}}, r_cur[n]} * {{WIDTH{1'b0}}, r_gain};
      w_x[n]      = w_prod[n][GAIN_BITS +: WIDTH];
      w_unused[n] = ^{w_prod[n][WIDTH+GW-1], w_prod[n][GAIN_BITS-1:0]};
      w_sum1[n]   = {1'b0, r_acc[n]} + {1'b0, w_x[n]};
      w_carry[n]  = w_sum1[n][WIDTH];
      w_y[n]      = !r_i2[n][IW-1];
      w_i1_nxt[n] = sat({{2{r_i1[n][IW-1]}}, r_i1[n]} + {{(EW-WIDTH){1'b0}}, w_x[n]}
                        - (w_y[n] ? FB_FULL : '0));
      w_i2_nxt[n] = sat({{2{r_i2[n][IW-1]}}, r_i2[n]} + {{2{r_i1[n][IW-1]}}, r_i1[n]}
                        - (w_y[n] ? FB_FULL : '0));
    end
  end

  // A mode change spends one tick clearing every integrator, then modulates in the new mode.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_order_q  <= 1'b0;
      r_clr_pend <= 1'b0;
      r_pdm      <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_acc[n] <= '0;
        r_i1[n]  <= '0;
        r_i2[n]  <= '0;
      end
    end else begin
      r_order_q <= order2_i;
      if (w_order_chg)  r_clr_pend <= 1'b1;
      else if (w_tick)  r_clr_pend <= 1'b0;
      if (w_tick) begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (r_clr_pend) begin
            r_acc[n] <= '0;
            r_i1[n]  <= '0;
            r_i2[n]  <= '0;
          end else if (r_order_q) begin
            r_i1[n] <= w_i1_nxt[n];
            r_i2[n] <= w_i2_nxt[n];
          end else begin
            r_acc[n] <= w_sum1[n][WIDTH-1:0];
          end
        end
      end
      if (w_muted_nxt)  r_pdm <= '0;
      else if (w_tick)  r_pdm <= r_clr_pend ? '0 : (r_order_q ? w_y : w_carry);
    end
  end
endmodule

// File: tb/tb_pdm_audio_dac.sv
// tb/tb_pdm_audio_dac.sv - directed self-checking bench for pdm_audio_dac
module tb_pdm_audio_dac;
  localparam int CH = 2;
  localparam int W  = 12;
  localparam int TD = 1;
  localparam int FT = 4;
  localparam int GB = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          order2 = 1'b0;
  logic          mute = 1'b0;
  logic [CH-1:0] pdm;
  logic          pdm_en, muted, underrun;
  int            n_total = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            c0, c1, alt_bad;

  pdm_audio_dac_if #(.CHANNELS(CH), .WIDTH(W)) s_if ();

  pdm_audio_dac #(
    .CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD), .FRAME_TICKS(FT), .GAIN_BITS(GB)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .s_if(s_if), .order2_i(order2), .mute_i(mute),
    .pdm_o(pdm), .pdm_en_o(pdm_en), .muted_o(muted), .underrun_o(underrun)
  );

  always #5 clk = ~clk;

  // Edges since reset release; with TICK_DIV=1 every edge is a tick and every FT-th a frame tick.
  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_frame();
    step(1);
    repeat (FT - 1) if ((cyc % FT) != 0) step(1);
  endtask

  task automatic push_frame(input logic [CH*W-1:0] d);
    s_if.sample       = d;
    s_if.sample_valid = 1'b1;
    step(1);
    s_if.sample_valid = 1'b0;
    to_frame();
  endtask

  task automatic count_ones(input int n, output int o0, output int o1, output int alt);
    logic prev;
    o0 = 0; o1 = 0; alt = 0; prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1);
      o0 += int'(pdm[0]);
      o1 += int'(pdm[1]);
      if (i > 0 && pdm[0] == prev) alt++;
      prev = pdm[0];
    end
  endtask

  initial begin
    s_if.sample = '0;
    s_if.sample_valid = 1'b0;
    step(3);
    chk("rst_ready", s_if.sample_ready, 0);
    chk("rst_en", pdm_en, 0);
    chk("rst_muted", muted, 0);
    chk("rst_pdm", pdm, 0);
    chk("rst_underrun", underrun, 0);

    rstn = 1'b1;
    step(1);
    chk("rel_muted", muted, 1);
    chk("rel_ready", s_if.sample_ready, 1);
    step(2);
    chk("en_before_ft", pdm_en, 0);
    step(1);
    chk("en_first_ft", pdm_en, 1);
    chk("muted_first_ft", muted, 0);
    chk("underrun_first_ft", underrun, 1);
    chk("gain_first_ft", dut.r_gain, 0);
    step(1);
    chk("underrun_pulse_end", underrun, 0);
    step(11);
    chk("gain_ramp3", dut.r_gain, 3);
    step(4);
    chk("gain_run", dut.r_gain, 4);
    step(4);
    chk("gain_run_hold", dut.r_gain, 4);

    s_if.sample = {12'h0A1, 12'h0A0};
    s_if.sample_valid = 1'b1;
    step(1);
    chk("fifo_ready_1", s_if.sample_ready, 1);
    s_if.sample = {12'h0B1, 12'h0B0};
    step(1);
    chk("fifo_ready_full", s_if.sample_ready, 0);
    s_if.sample = {12'h0C1, 12'h0C0};
    step(1);
    chk("fifo_ready_full2", s_if.sample_ready, 0);
    step(1);
    chk("fifo_ready_after_pop", s_if.sample_ready, 1);
    chk("fifo_pop_a", dut.r_cur[0], 12'h0A0);
    step(1);
    chk("fifo_ready_refill", s_if.sample_ready, 0);
    s_if.sample_valid = 1'b0;
    step(3);
    chk("fifo_pop_b", dut.r_cur[0], 12'h0B0);
    chk("fifo_no_underrun_b", underrun, 0);
    step(4);
    chk("fifo_pop_c1", dut.r_cur[1], 12'h0C1);
    chk("fifo_no_underrun_c", underrun, 0);
    step(4);
    chk("underrun_3rd_ft", underrun, 1);
    chk("underrun_hold", dut.r_cur[0], 12'h0C0);
    step(1);
    chk("underrun_clear", underrun, 0);
    to_frame();

    push_frame({12'hFFF, 12'h800});
    count_ones(4096, c0, c1, alt_bad);
    chk("o1_half_ones", c0, 2048);
    chk("o1_half_alt", alt_bad, 0);
    chk("o1_full_ones", c1, 4095);
    push_frame({12'h800, 12'h000});
    count_ones(4096, c0, c1, alt_bad);
    chk("o1_zero_ones", c0, 0);
    chk("o1_half_ch1", c1, 2048);

    mute = 1'b1;
    to_frame();
    chk("mute_g3", dut.r_gain, 3);
    chk("mute_en_still", pdm_en, 1);
    to_frame();
    chk("mute_g2", dut.r_gain, 2);
    mute = 1'b0;
    to_frame();
    chk("reverse_g3", dut.r_gain, 3);
    to_frame();
    chk("reverse_g4", dut.r_gain, 4);
    mute = 1'b1;
    to_frame();
    to_frame();
    to_frame();
    chk("down_g1", dut.r_gain, 1);
    chk("down_en_g1", pdm_en, 1);
    to_frame();
    chk("down_g0", dut.r_gain, 0);
    chk("down_muted", muted, 1);
    chk("down_en", pdm_en, 0);
    chk("down_pdm", pdm, 0);
    step(5);
    chk("muted_pdm_hold", pdm, 0);
    mute = 1'b0;
    to_frame();
    chk("unmute_en", pdm_en, 1);
    repeat (4) to_frame();
    chk("unmute_run", dut.r_gain, 4);

    push_frame({12'h000, 12'h400});
    order2 = 1'b1;
    step(2);
    chk("o2_clr_i1", {16'h0, dut.r_i1[0]}, 0);
    chk("o2_clr_i2", {16'h0, dut.r_i2[0]}, 0);
    chk("o2_clr_pdm", pdm[0], 0);
    count_ones(4096, c0, c1, alt_bad);
    chk("o2_quarter_range", (c0 >= 1022 && c0 <= 1026), 1);
    chk("o2_zero_ones", c1, 1);
    chk("o2_sat_lo", {16'h0, dut.r_i2[1]}, 32'h0000_8000);
    order2 = 1'b0;
    step(2);
    chk("o1_clr_sat_i2", {16'h0, dut.r_i2[1]}, 0);
    chk("o1_clr_acc", dut.r_acc[0], 0);
    count_ones(4096, c0, c1, alt_bad);
    chk("o1_quarter_ones", c0, 1024);
    chk("o1_back_zero", c1, 0);

    to_frame();
    mute = 1'b1;
    repeat (4) to_frame();
    chk("pre_rst_muted", muted, 1);
    mute = 1'b0;
    to_frame();
    to_frame();
    s_if.sample = {12'h123, 12'h456};
    s_if.sample_valid = 1'b1;
    step(2);
    s_if.sample_valid = 1'b0;
    chk("pre_rst_full", s_if.sample_ready, 0);
    chk("pre_rst_gain", dut.r_gain, 1);
    step(1);
    rstn = 1'b0;
    step(1);
    chk("mid_rst_ready", s_if.sample_ready, 0);
    chk("mid_rst_en", pdm_en, 0);
    chk("mid_rst_muted", muted, 0);
    chk("mid_rst_pdm", pdm, 0);
    chk("mid_rst_gain", dut.r_gain, 0);
    chk("mid_rst_count", dut.r_count, 0);
    step(2);
    chk("mid_rst_ready_hold", s_if.sample_ready, 0);
    rstn = 1'b1;
    step(1);
    chk("post_rst_ready", s_if.sample_ready, 1);
    chk("post_rst_muted", muted, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
